aes_cipher_ctrl: RTL and testbench

- Sequencer for the iterative AES-128 encryption datapath, which runs one round per clock and is steered by a 2-bit round-state input.
- Accepts a block via a valid/ready handshake, registers the plaintext, and drives the datapath state code and a round index to the round-key store.
- Captures the ciphertext when the datapath flags completion and holds it in an output buffer until the consumer accepts it.
- Sits between the host/bus-side request logic and the cipher datapath plus round-key store.

---
 rtl/aes_cipher_ctrl_if.sv | 36 +++
 rtl/aes_cipher_ctrl.sv | 113 +++++++++++
 tb/tb_aes_cipher_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_cipher_ctrl_if.sv
// rtl/aes_cipher_ctrl_if.sv - host, datapath and result-buffer signals of the AES-128 round sequencer
interface aes_cipher_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             start_valid;
  logic             start_ready;
  logic [31:0]      pt0_in, pt1_in, pt2_in, pt3_in;
  logic             abort_in;
  logic [1:0]       dp_state_out;
  logic [31:0]      dp_pt0_out, dp_pt1_out, dp_pt2_out, dp_pt3_out;
  logic [3:0]       rk_idx_out;
  logic [31:0]      dp_ct0_in, dp_ct1_in, dp_ct2_in, dp_ct3_in;
  logic             dp_valid_in;
  logic [31:0]      ct0_out, ct1_out, ct2_out, ct3_out;
  logic             out_valid;
  logic             out_ready;
  logic             busy_out;
  logic             err_out;
  logic [CNT_W-1:0] done_cnt_out;

  modport master (
    output start_valid, pt0_in, pt1_in, pt2_in, pt3_in, abort_in,
           dp_ct0_in, dp_ct1_in, dp_ct2_in, dp_ct3_in, dp_valid_in, out_ready,
    input  start_ready, dp_state_out, dp_pt0_out, dp_pt1_out, dp_pt2_out, dp_pt3_out,
           rk_idx_out, ct0_out, ct1_out, ct2_out, ct3_out, out_valid, busy_out,
           err_out, done_cnt_out
  );

  modport slave (
    input  start_valid, pt0_in, pt1_in, pt2_in, pt3_in, abort_in,
           dp_ct0_in, dp_ct1_in, dp_ct2_in, dp_ct3_in, dp_valid_in, out_ready,
    output start_ready, dp_state_out, dp_pt0_out, dp_pt1_out, dp_pt2_out, dp_pt3_out,
           rk_idx_out, ct0_out, ct1_out, ct2_out, ct3_out, out_valid, busy_out,
           err_out, done_cnt_out
  );
endinterface

// File: rtl/aes_cipher_ctrl.sv
// rtl/aes_cipher_ctrl.sv - sequencer for an iterative one-round-per-clock AES-128 datapath
module aes_cipher_ctrl #(
  parameter int NUM_ROUNDS = 10,
  parameter int CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RST,
  aes_cipher_ctrl_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_R0, S_RMID, S_RLAST, S_WAIT} state_e;

  localparam logic [3:0] LAST_MID = 4'(NUM_ROUNDS - 1);
  localparam logic [3:0] LAST_RK  = 4'(NUM_ROUNDS);

  state_e           state_q;
  logic [1:0]       dp_state_q;
  logic [3:0]       rnd_q;
  logic [127:0]     pt_q;
  logic [127:0]     ct_q;
  logic             out_valid_q;
  logic             err_q;
  logic [CNT_W-1:0] done_cnt_q;
  logic             start_ready;
  logic             accept;

  // A drain in the same cycle frees the buffer, so a new block may start alongside it.
  assign start_ready = !RST && (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept      = bus.start_valid && start_ready;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      dp_state_q  <= 2'd0;
      rnd_q       <= 4'd0;
      pt_q        <= '0;
      ct_q        <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      done_cnt_q  <= '0;
    end else begin
      if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      // Abort outranks every in-flight state, including the capture in S_WAIT.
      if (state_q != S_IDLE && bus.abort_in) begin
        state_q    <= S_IDLE;
        dp_state_q <= 2'd0;
        rnd_q      <= 4'd0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (accept) begin
              pt_q       <= {bus.pt0_in, bus.pt1_in, bus.pt2_in, bus.pt3_in};
              state_q    <= S_R0;
              dp_state_q <= 2'd1;
              rnd_q      <= 4'd0;
            end
          end
          S_R0: begin
            state_q    <= S_RMID;
            dp_state_q <= 2'd2;
            rnd_q      <= 4'd1;
          end
          S_RMID: begin
            if (rnd_q == LAST_MID) begin
              state_q    <= S_RLAST;
              dp_state_q <= 2'd3;
              rnd_q      <= LAST_RK;
            end else begin
              rnd_q <= rnd_q + 4'd1;
            end
          end
          S_RLAST: begin
            state_q    <= S_WAIT;
            dp_state_q <= 2'd0;
            rnd_q      <= 4'd0;
          end
          S_WAIT: begin
            state_q <= S_IDLE;
            if (bus.dp_valid_in) begin
              ct_q        <= {bus.dp_ct0_in, bus.dp_ct1_in, bus.dp_ct2_in, bus.dp_ct3_in};
              out_valid_q <= 1'b1;
              done_cnt_q  <= done_cnt_q + CNT_W'(1);
            end else begin
              err_q <= 1'b1;
            end
          end
          default: begin
            state_q    <= S_IDLE;
            dp_state_q <= 2'd0;
            rnd_q      <= 4'd0;
          end
        endcase
      end
    end
  end

  assign bus.start_ready  = start_ready;
  assign bus.dp_state_out = dp_state_q;
  assign bus.rk_idx_out   = rnd_q;
  assign bus.dp_pt0_out   = pt_q[127:96];
  assign bus.dp_pt1_out   = pt_q[95:64];
  assign bus.dp_pt2_out   = pt_q[63:32];
  assign bus.dp_pt3_out   = pt_q[31:0];
  assign bus.ct0_out      = ct_q[127:96];
  assign bus.ct1_out      = ct_q[95:64];
  assign bus.ct2_out      = ct_q[63:32];
  assign bus.ct3_out      = ct_q[31:0];
  assign bus.out_valid    = out_valid_q;
  assign bus.busy_out     = (state_q != S_IDLE);
  assign bus.err_out      = err_q;
  assign bus.done_cnt_out = done_cnt_q;
endmodule

// File: tb/tb_aes_cipher_ctrl.sv
// tb/tb_aes_cipher_ctrl.sv - scoreboard bench with a bench-side AES datapath, key store and reference cipher
module tb_aes_cipher_ctrl;
  localparam int CNT_W = 2;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  aes_cipher_ctrl_if #(.CNT_W(CNT_W)) bus ();
  aes_cipher_ctrl #(.NUM_ROUNDS(10), .CNT_W(CNT_W)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_done = 0;
  bit kill_valid = 1'b0;
  bit rand_ready = 1'b0;

  logic [7:0]   sb [0:255];
  logic [127:0] rk [0:10];

  typedef struct {
    logic [127:0] ct;
    int           done;
    int           cyc;
  } exp_t;
  exp_t sbq[$];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = xt(x);
    end
    return r;
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = sb[s[127-8*(r+4*((c+r)%4)) -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  task automatic set_key(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk[0];
    for (int r = 1; r < 10; r++) s = mix(sub_shift(s)) ^ rk[r];
    return sub_shift(s) ^ rk[10];
  endfunction

  // Bench-side datapath: one round per clock, steered by the controller's state code and key index.
  logic [127:0] dp_s = '0;
  logic         dpv_q = 1'b0;
  always @(posedge CLK) begin
    case (bus.dp_state_out)
      2'd1: dp_s <= {bus.dp_pt0_out, bus.dp_pt1_out, bus.dp_pt2_out, bus.dp_pt3_out} ^ rk[bus.rk_idx_out];
      2'd2: dp_s <= mix(sub_shift(dp_s)) ^ rk[bus.rk_idx_out];
      2'd3: dp_s <= sub_shift(dp_s) ^ rk[bus.rk_idx_out];
      default: ;
    endcase
    dpv_q <= (bus.dp_state_out == 2'd3);
  end
  assign bus.dp_ct0_in   = dp_s[127:96];
  assign bus.dp_ct1_in   = dp_s[95:64];
  assign bus.dp_ct2_in   = dp_s[63:32];
  assign bus.dp_ct3_in   = dp_s[31:0];
  assign bus.dp_valid_in = dpv_q & ~kill_valid;

  always @(posedge CLK) begin
    if (rand_ready) begin
      #1;
      bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: each fresh result pops one expectation; a held result must not change.
  logic         prev_hold = 1'b0;
  logic [127:0] held = '0;
  always @(negedge CLK) begin
    logic [127:0] ct_now;
    exp_t e;
    ct_now = {bus.ct0_out, bus.ct1_out, bus.ct2_out, bus.ct3_out};
    if (!RST && bus.out_valid) begin
      if (prev_hold) begin
        chk("ct_stable", ct_now, held);
      end else if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%h required=none (cycle %0d)", ct_now, cyc);
      end else begin
        e = sbq.pop_front();
        chk("ct", ct_now, e.ct);
        chk("done_cnt", 128'(bus.done_cnt_out), 128'(e.done));
        chk("latency", 128'(cyc), 128'(e.cyc));
      end
    end
    prev_hold = !RST && bus.out_valid && !bus.out_ready;
    held = ct_now;
  end

  task automatic run_block(input logic [127:0] pt, input bit good, output int t_acc);
    exp_t e;
    int n = 0;
    bus.pt0_in = pt[127:96]; bus.pt1_in = pt[95:64];
    bus.pt2_in = pt[63:32];  bus.pt3_in = pt[31:0];
    bus.start_valid = 1'b1;
    @(negedge CLK);
    while (!bus.start_ready && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("accept_in_time", 128'(n < 200), 128'(1));
    t_acc = cyc;
    if (good) begin
      exp_done = (exp_done + 1) % (1 << CNT_W);
      e.ct = aes_ref(pt);
      e.done = exp_done;
      e.cyc = cyc + 13;
      sbq.push_back(e);
    end
    @(posedge CLK);
    #1;
    bus.start_valid = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t, tprev, tc;
    logic [127:0] fips_pt, fips_ct;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] inv;
      inv = 8'h01;
      for (int j = 0; j < 254; j++) inv = gmul(inv, 8'(i));
      sb[i] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    fips_pt = 128'h00112233445566778899aabbccddeeff;
    fips_ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    set_key(128'h000102030405060708090a0b0c0d0e0f);
    bus.start_valid = 1'b0; bus.abort_in = 1'b0; bus.out_ready = 1'b1;
    bus.pt0_in = '0; bus.pt1_in = '0; bus.pt2_in = '0; bus.pt3_in = '0;

    // reset state
    step(3);
    @(negedge CLK);
    chk("rst_dp_state", 128'(bus.dp_state_out), 128'(0));
    chk("rst_rk_idx", 128'(bus.rk_idx_out), 128'(0));
    chk("rst_dp_pt", {bus.dp_pt0_out, bus.dp_pt1_out, bus.dp_pt2_out, bus.dp_pt3_out}, 128'(0));
    chk("rst_ct", {bus.ct0_out, bus.ct1_out, bus.ct2_out, bus.ct3_out}, 128'(0));
    chk("rst_flags", {bus.out_valid, bus.err_out, bus.busy_out}, 128'(0));
    chk("rst_done_cnt", 128'(bus.done_cnt_out), 128'(0));
    step(1);
    RST = 1'b0;
    @(negedge CLK);
    chk("start_ready_after_rst", 128'(bus.start_ready), 128'(1));
    step(1);

    // FIPS-197 vector with state/index sequence
    chk("ref_model_fips", aes_ref(fips_pt), fips_ct);
    run_block(fips_pt, 1'b1, t);
    @(negedge CLK);
    chk("dp_pt_reg", {bus.dp_pt0_out, bus.dp_pt1_out, bus.dp_pt2_out, bus.dp_pt3_out}, fips_pt);
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) @(negedge CLK);
      chk($sformatf("dp_state_T%0d", k), 128'(bus.dp_state_out),
          128'((k == 1) ? 1 : (k <= 10) ? 2 : (k == 11) ? 3 : 0));
      chk($sformatf("rk_idx_T%0d", k), 128'(bus.rk_idx_out), 128'((k <= 11) ? k - 1 : 0));
    end
    @(negedge CLK);
    chk("fips_ct", {bus.ct0_out, bus.ct1_out, bus.ct2_out, bus.ct3_out}, fips_ct);
    chk("fips_done_cnt", 128'(bus.done_cnt_out), 128'(1));
    step(1);

    // backpressure, then drain together with a new accept
    set_key(rnd128());
    run_block(rnd128(), 1'b1, t);
    bus.out_ready = 1'b0;
    step(12);
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      chk("bp_start_ready", 128'(bus.start_ready), 128'(0));
      chk("bp_out_valid", 128'(bus.out_valid), 128'(1));
      step(1);
    end
    bus.out_ready = 1'b1;
    tc = cyc;
    run_block(rnd128(), 1'b1, t);
    chk("drain_accept_same_cycle", 128'(t), 128'(tc));
    @(negedge CLK);
    chk("drain_out_valid_fell", 128'(bus.out_valid), 128'(0));
    step(14);

    // abort in S_RMID at T+5
    run_block(rnd128(), 1'b0, t);
    step(4);
    bus.abort_in = 1'b1;
    @(negedge CLK);
    chk("abort_rk_idx", 128'(bus.rk_idx_out), 128'(4));
    step(1);
    bus.abort_in = 1'b0;
    @(negedge CLK);
    chk("abort_dp_state", 128'(bus.dp_state_out), 128'(0));
    chk("abort_busy", 128'(bus.busy_out), 128'(0));
    chk("abort_done_cnt", 128'(bus.done_cnt_out), 128'(exp_done));
    step(12);
    run_block(rnd128(), 1'b1, t);
    step(14);

    // missing completion flag
    kill_valid = 1'b1;
    run_block(rnd128(), 1'b0, t);
    step(12);
    @(negedge CLK);
    chk("err_set", 128'(bus.err_out), 128'(1));
    chk("err_no_out_valid", 128'(bus.out_valid), 128'(0));
    step(1);
    kill_valid = 1'b0;
    run_block(rnd128(), 1'b1, t);
    step(14);
    @(negedge CLK);
    chk("err_sticky", 128'(bus.err_out), 128'(1));
    step(1);

    // reset in the middle of a block
    run_block(rnd128(), 1'b0, t);
    step(7);
    RST = 1'b1;
    step(1);
    exp_done = 0;
    @(negedge CLK);
    chk("midrst_dp_state_rk", {bus.dp_state_out, bus.rk_idx_out}, 128'(0));
    chk("midrst_dp_pt", {bus.dp_pt0_out, bus.dp_pt1_out, bus.dp_pt2_out, bus.dp_pt3_out}, 128'(0));
    chk("midrst_ct", {bus.ct0_out, bus.ct1_out, bus.ct2_out, bus.ct3_out}, 128'(0));
    chk("midrst_flags", {bus.out_valid, bus.err_out, bus.busy_out}, 128'(0));
    chk("midrst_done_cnt", 128'(bus.done_cnt_out), 128'(0));
    step(1);
    RST = 1'b0;
    @(negedge CLK);
    chk("midrst_start_ready", 128'(bus.start_ready), 128'(1));
    step(1);

    // back-to-back blocks across the counter wrap
    set_key(rnd128());
    tprev = 0;
    for (int i = 0; i < 5; i++) begin
      run_block(rnd128(), 1'b1, t);
      if (i > 0) chk("b2b_spacing", 128'(t - tprev), 128'(13));
      tprev = t;
    end
    step(14);

    // randomized blocks under random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_key(rnd128());
      run_block(rnd128(), 1'b1, t);
      step(13 + int'($urandom_range(0, 3)));
    end
    rand_ready = 1'b0;
    step(1);
    bus.out_ready = 1'b1;
    step(20);
    chk("scoreboard_empty", 128'(sbq.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
